// File: rtl/cpu_pipe_ctrl_if.sv
// Pipeline-control bus: hazard/status inputs from the stages and stall/bubble
// controls back to the pipeline registers and data-memory port.
interface cpu_pipe_ctrl_if #(parameter int CNT_W = 16);
  logic [2:0]       d_srca, d_srcb, e_dst, m_dst;
  logic             d_srca_valid, d_srcb_valid;
  logic             e_valid, e_dstr_cs, e_dstr_cs_e, e_dstr_cs_m, e_br_miss;
  logic             m_valid, m_dstr_cs, m_dstr_cs_m, m_mem_rd, m_mem_wr;
  logic             mem_ack, w_valid, w_hlt, int_req;
  logic             f_stall, d_stall, e_stall, m_stall;
  logic             d_bubble, e_bubble, w_bubble;
  logic             mem_req, halted, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_srca, d_srca_valid, d_srcb, d_srcb_valid,
           e_dst, e_valid, e_dstr_cs, e_dstr_cs_e, e_dstr_cs_m, e_br_miss,
           m_dst, m_valid, m_dstr_cs, m_dstr_cs_m, m_mem_rd, m_mem_wr,
           mem_ack, w_valid, w_hlt, int_req,
    input  f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, w_bubble,
           mem_req, halted, mem_err, stall_cnt
  );

  modport slave (
    input  d_srca, d_srca_valid, d_srcb, d_srcb_valid,
           e_dst, e_valid, e_dstr_cs, e_dstr_cs_e, e_dstr_cs_m, e_br_miss,
           m_dst, m_valid, m_dstr_cs, m_dstr_cs_m, m_mem_rd, m_mem_wr,
           mem_ack, w_valid, w_hlt, int_req,
    output f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, w_bubble,
           mem_req, halted, mem_err, stall_cnt
  );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline control for the 5-stage core: stalls/bubbles for unforwardable
// hazards, mispredicts and memory waits, plus HLT/interrupt and timeout handling.
module cpu_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  cpu_pipe_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, MWAIT, HALT} state_t;

  state_t           state, nxt;
  logic [7:0]       tcnt;
  logic             halted, mem_err, tout;
  logic [CNT_W-1:0] stall_cnt;

  logic memop, hold, hltw, mispred, lu;
  logic fs, ds, es, ms, db, eb, wb, req;

  function automatic logic srcmatch(input logic [2:0] x);
    return (bus.d_srca_valid && bus.d_srca == x) ||
           (bus.d_srcb_valid && bus.d_srcb == x);
  endfunction

  assign memop   = bus.m_valid & (bus.m_mem_rd | bus.m_mem_wr);
  assign hold    = memop & ~bus.mem_ack;
  assign hltw    = bus.w_valid & bus.w_hlt;
  assign mispred = bus.e_valid & bus.e_br_miss;
  // Only values still in flight (load data, or E result not yet written) block D.
  assign lu = (srcmatch(bus.e_dst) & bus.e_valid & bus.e_dstr_cs &
               (bus.e_dstr_cs_e | bus.e_dstr_cs_m)) |
              (srcmatch(bus.m_dst) & bus.m_valid & bus.m_dstr_cs & bus.m_dstr_cs_m);

  always_comb begin
    nxt = state;
    {fs, ds, es, ms, db, eb, wb, req} = '0;
    tout = 1'b0;
    if (rst) begin
      nxt = RUN;
      {db, eb, wb} = 3'b111;
    end else if (state == HALT) begin
      if (bus.int_req && !mem_err) begin
        nxt = RUN;
        {db, eb} = 2'b11;
      end else begin
        {fs, ds, es, ms, wb} = 5'b11111;
      end
    end else begin
      req = memop;
      if (hltw) begin
        {fs, ds, es, ms, wb} = 5'b11111;
        req = 1'b0;
        nxt = HALT;
      end else if (hold) begin
        {fs, ds, es, ms, wb} = 5'b11111;
        if (state == MWAIT && tcnt == 8'(MEM_TIMEOUT)) begin
          req  = 1'b0;
          tout = 1'b1;
          nxt  = HALT;
        end else begin
          nxt = MWAIT;
        end
      end else begin
        nxt = RUN;
        if (mispred)
          {db, eb} = 2'b11;
        else if (lu)
          {fs, ds, eb} = 3'b111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      tcnt      <= '0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= nxt;
      tcnt   <= (state == MWAIT && nxt == MWAIT) ? tcnt + 8'd1 : 8'd0;
      halted <= (nxt == HALT);
      if (tout)
        mem_err <= 1'b1;
      if (fs && state != HALT && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.f_stall   = fs;
  assign bus.d_stall   = ds;
  assign bus.e_stall   = es;
  assign bus.m_stall   = ms;
  assign bus.d_bubble  = db;
  assign bus.e_bubble  = eb;
  assign bus.w_bubble  = wb;
  assign bus.mem_req   = req;
  assign bus.halted    = halted;
  assign bus.mem_err   = mem_err;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl (MEM_TIMEOUT=4, CNT_W=4) with a per-cycle
// expected-output scoreboard.
module tb_cpu_pipe_ctrl;
  localparam int CW = 4;
  // control vector order: {f_stall,d_stall,e_stall,m_stall,d_bub,e_bub,w_bub,mem_req}
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] LUS   = 8'b1100_0100;
  localparam logic [7:0] MISP  = 8'b0000_1100;
  localparam logic [7:0] HOLDV = 8'b1111_0011;
  localparam logic [7:0] HALTV = 8'b1111_0010;
  localparam logic [7:0] RSTV  = 8'b0000_1110;
  localparam logic [7:0] REQ   = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0, passes = 0;
  logic [13:0] sb[$];

  cpu_pipe_ctrl_if #(.CNT_W(CW)) bus();
  cpu_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    bus.d_srca = 3'd0; bus.d_srca_valid = 1'b0; bus.d_srcb = 3'd0; bus.d_srcb_valid = 1'b0;
    bus.e_dst = 3'd0; bus.e_valid = 1'b0; bus.e_dstr_cs = 1'b0; bus.e_dstr_cs_e = 1'b0;
    bus.e_dstr_cs_m = 1'b0; bus.e_br_miss = 1'b0;
    bus.m_dst = 3'd0; bus.m_valid = 1'b0; bus.m_dstr_cs = 1'b0; bus.m_dstr_cs_m = 1'b0;
    bus.m_mem_rd = 1'b0; bus.m_mem_wr = 1'b0; bus.mem_ack = 1'b0;
    bus.w_valid = 1'b0; bus.w_hlt = 1'b0; bus.int_req = 1'b0;
  endtask

  task automatic e_load_use(input logic cs_e, input logic cs_m);
    idle();
    bus.e_valid = 1'b1; bus.e_dstr_cs = 1'b1; bus.e_dst = 3'd3;
    bus.e_dstr_cs_e = cs_e; bus.e_dstr_cs_m = cs_m;
    bus.d_srca = 3'd3; bus.d_srca_valid = 1'b1;
  endtask

  task automatic mem_rd();
    idle();
    bus.m_valid = 1'b1; bus.m_mem_rd = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic [7:0] ctl, input logic h,
                     input logic e, input logic [CW-1:0] c);
    logic [13:0] exp, obs;
    sb.push_back({ctl, h, e, c});
    @(negedge clk);
    exp = sb.pop_front();
    obs = {bus.f_stall, bus.d_stall, bus.e_stall, bus.m_stall, bus.d_bubble,
           bus.e_bubble, bus.w_bubble, bus.mem_req, bus.halted, bus.mem_err, bus.stall_cnt};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    e_load_use(1'b0, 1'b1);
    cyc("reset_override", RSTV, 0, 0, 4'd0);
    rst = 1'b0;
    idle();                 cyc("idle",          NONE, 0, 0, 4'd0);
    e_load_use(1'b0, 1'b1); cyc("lu_load",       LUS,  0, 0, 4'd0);
    idle();                 cyc("lu_release",    NONE, 0, 0, 4'd1);
    e_load_use(1'b0, 1'b0); cyc("no_lu_csr",     NONE, 0, 0, 4'd1);
    e_load_use(1'b1, 1'b0); cyc("lu_alu_e",      LUS,  0, 0, 4'd1);
    idle();
    bus.m_valid = 1'b1; bus.m_dstr_cs = 1'b1; bus.m_dstr_cs_m = 1'b1; bus.m_dst = 3'd5;
    bus.d_srcb = 3'd5; bus.d_srcb_valid = 1'b1;
    cyc("lu_m_load", LUS, 0, 0, 4'd2);
    bus.m_dstr_cs_m = 1'b0; cyc("no_lu_m_alu",   NONE, 0, 0, 4'd3);
    e_load_use(1'b0, 1'b1); bus.e_br_miss = 1'b1;
    cyc("mispred_over_lu", MISP, 0, 0, 4'd3);

    mem_rd(); cyc("mrd_c1", HOLDV, 0, 0, 4'd3);
    cyc("mrd_c2", HOLDV, 0, 0, 4'd4);
    cyc("mrd_c3", HOLDV, 0, 0, 4'd5);
    bus.mem_ack = 1'b1; cyc("mrd_ack", REQ, 0, 0, 4'd6);
    idle();   cyc("mrd_done", NONE, 0, 0, 4'd6);
    mem_rd(); bus.mem_ack = 1'b1; cyc("mrd_ack_first", REQ, 0, 0, 4'd6);

    mem_rd(); bus.w_valid = 1'b1; bus.w_hlt = 1'b1;
    cyc("hlt_enter", HALTV, 0, 0, 4'd6);
    mem_rd(); cyc("halt_1", HALTV, 1, 0, 4'd7);
    cyc("halt_2", HALTV, 1, 0, 4'd7);
    idle(); bus.int_req = 1'b1; cyc("halt_exit", MISP, 1, 0, 4'd7);
    idle(); cyc("run_after_int", NONE, 0, 0, 4'd7);

    mem_rd(); cyc("to_run", HOLDV, 0, 0, 4'd7);
    for (int i = 0; i < 4; i++) cyc("to_wait", HOLDV, 0, 0, 4'(8 + i));
    cyc("to_expire", HALTV, 0, 0, 4'd12);
    idle(); bus.int_req = 1'b1;
    cyc("err_int_ignored1", HALTV, 1, 1, 4'd13);
    cyc("err_int_ignored2", HALTV, 1, 1, 4'd13);
    rst = 1'b1; cyc("err_reset", RSTV, 1, 1, 4'd13);
    rst = 1'b0; idle(); cyc("err_cleared", NONE, 0, 0, 4'd0);

    mem_rd(); cyc("ackto_run", HOLDV, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) cyc("ackto_wait", HOLDV, 0, 0, 4'(1 + i));
    bus.mem_ack = 1'b1; cyc("ackto_ack_wins", REQ, 0, 0, 4'd5);
    idle(); cyc("ackto_no_err", NONE, 0, 0, 4'd5);

    e_load_use(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc("sat", LUS, 0, 0, 4'((5 + i > 15) ? 15 : 5 + i));
    idle(); cyc("sat_hold", NONE, 0, 0, 4'd15);

    mem_rd(); cyc("rmw_run", HOLDV, 0, 0, 4'd15);
    cyc("rmw_wait", HOLDV, 0, 0, 4'd15);
    rst = 1'b1; cyc("rmw_reset", RSTV, 0, 0, 4'd15);
    rst = 1'b0; idle(); cyc("rmw_after", NONE, 0, 0, 4'd0);
    mem_rd(); cyc("rmw_restart", HOLDV, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) cyc("rmw_rewait", HOLDV, 0, 0, 4'(1 + i));
    cyc("rmw_timeout", HALTV, 0, 0, 4'd5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
- Pipeline control unit for the 8-bit five-stage core (F/D/E/M/W).
- Generates per-stage stall and bubble controls from three sources: hazards the forwarding network cannot cover, E-stage branch mispredicts, and multi-cycle data-memory handshakes.
- Sequences HLT/interrupt halting and keeps a memory-timeout watchdog and a stall performance counter.
- Sits beside the forwarding mux and drives the pipeline register enables and clears.

Parameters:
MEM_TIMEOUT, 255, MWAIT cycles without ack before error (1..255)
CNT_W, 16, stall counter width

Ports:
CLK_I  in  1  clock
RST_I  in  1  synchronous active-high reset
D_SRCA_I  in  3  D-stage source register A
D_SRCA_VALID_I  in  1  D instruction reads SRCA
D_SRCB_I  in  3  D-stage source register B
D_SRCB_VALID_I  in  1  D instruction reads SRCB
E_DST_I, E_VALID_I, E_DSTR_CS_I  in  3,1,1  E dest, valid, writes reg
E_DSTR_CS_E_I, E_DSTR_CS_M_I  in  1,1  E result is ALU value / memory value
E_BR_MISS_I  in  1  E-stage branch mispredicted
M_DST_I, M_VALID_I, M_DSTR_CS_I, M_DSTR_CS_M_I  in  3,1,1,1  M dest, valid, writes reg, result is memory value
M_MEM_RD_I, M_MEM_WR_I  in  1,1  M instruction accesses data memory
MEM_ACK_I  in  1  data memory completes access this cycle
W_VALID_I, W_HLT_I  in  1,1  W holds valid HLT
INT_I  in  1  interrupt request (wakes HALT)
F_STALL_O, D_STALL_O, E_STALL_O, M_STALL_O  out  1 each  hold stage register
D_BUBBLE_O, E_BUBBLE_O, W_BUBBLE_O  out  1 each  load NOP into stage register
MEM_REQ_O  out  1  data-memory request
HALTED_O  out  1  core halted
MEM_ERR_O  out  1  sticky memory timeout
STALL_CNT_O  out  CNT_W  saturating count of F-stall cycles

Behaviour:
- States: RUN, MWAIT, HALT. Registered: state, timeout counter (8b), MEM_ERR_O, HALTED_O, STALL_CNT_O. Stage controls and MEM_REQ_O are combinational from state and inputs.
- Reset (RST_I=1 in a cycle): next state=RUN; counters, HALTED_O and MEM_ERR_O cleared. Same-cycle override: all STALL=0, D/E/W_BUBBLE=1, MEM_REQ_O=0. Reset mid-MWAIT abandons the access.
- Signal definitions:
  - MEMOP = M_VALID_I & (M_MEM_RD_I | M_MEM_WR_I).
  - HOLD = MEMOP & ~MEM_ACK_I.
  - srcmatch(x) = (SRCA valid & SRCA==x) | (SRCB valid & SRCB==x).
  - LU = srcmatch(E_DST_I) & E_VALID_I & E_DSTR_CS_I & (E_DSTR_CS_E_I | E_DSTR_CS_M_I), OR srcmatch(M_DST_I) & M_VALID_I & M_DSTR_CS_I & M_DSTR_CS_M_I. These are the values forwarding cannot supply.
  - HLTW = W_VALID_I & W_HLT_I.
- Priority in RUN/MWAIT, first match wins:
  1. HLTW: F/D/E/M_STALL=1, W_BUBBLE=1, MEM_REQ_O=0; next state HALT.
  2. HOLD: F/D/E/M_STALL=1, W_BUBBLE=1, MEM_REQ_O=1, D/E_BUBBLE=0; next state MWAIT.
  3. E_VALID_I & E_BR_MISS_I: D_BUBBLE=1, E_BUBBLE=1, no stalls. The mispredict overrides LU.
  4. LU: F_STALL=1, D_STALL=1, E_BUBBLE=1.
  5. Otherwise all controls 0.
  - MEM_REQ_O=MEMOP whenever HLTW is not active.
  - The MEM_ACK_I cycle releases all stalls, then rules 3–5 apply; next state RUN. Access latency with ack in the first cycle is 0 stall cycles.
- MWAIT timeout:
  - Counter increments each MWAIT cycle; it is zeroed on entry to MWAIT and on leaving it.
  - When counter==MEM_TIMEOUT and no ack: MEM_ERR_O<=1, next state HALT, MEM_REQ_O=0 that cycle.
  - An ack arriving in the timeout cycle wins: no error.
- HALT:
  - HALTED_O=1, registered on HALT entry.
  - F/D/E/M_STALL=1, W_BUBBLE=1, MEM_REQ_O=0.
  - INT_I=1 and MEM_ERR_O=0: next state RUN. The exit cycle asserts D_BUBBLE and E_BUBBLE, no stalls; HALTED_O clears with the transition.
  - MEM_ERR_O=1: HALT persists until reset; INT_I is ignored.
- STALL_CNT_O: +1 every cycle F_STALL_O=1 in RUN or MWAIT, never in HALT or reset. Saturates at all-ones with no wrap.

Test Plan:
- Load-use: E_VALID=1, E_DSTR_CS=1, CS_M=1, E_DST=3; D_SRCA=3 valid -> F_STALL=D_STALL=E_BUBBLE=1 for 1 cycle; STALL_CNT_O 0->1. Repeat with E_DSTR_CS_C only -> no stall.
- Mispredict plus LU in the same cycle -> D_BUBBLE=E_BUBBLE=1, F_STALL=D_STALL=0.
- Memory read with ack on 4th cycle -> MEM_REQ_O=1 for 4 cycles; all stalls and W_BUBBLE for 3 cycles; state MWAIT then RUN; STALL_CNT_O +=3.
- MEM_TIMEOUT=4, no ack -> MEM_ERR_O=1 and HALTED_O=1 after the timeout cycle; INT_I ignored; RST_I clears both next cycle.
- HLT in W while M has pending memory op -> HALT, MEM_REQ_O=0; INT_I pulse -> one cycle D/E_BUBBLE, then RUN, HALTED_O=0.
- Counter saturation with CNT_W=4: 20 LU stall cycles -> STALL_CNT_O=15 and stays at 15.
